// File: rtl/seg7_pkg.sv
// Shared seven-segment encoding: active-high {g,f,e,d,c,b,a} codes for hex digits.
package seg7_pkg;

    localparam logic [15:0][6:0] SEG_CODE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return SEG_CODE[nib];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high segment code.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] code
);

    assign code = hex2seg(nib);

endmodule

// File: rtl/seven_seg_scanner.sv
// N-digit multiplexed seven-segment driver with prescaled scan, frame snapshots,
// leading-zero blanking and PWM brightness.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [2:0]              bright,
    output logic [NUM_DIGITS-1:0]   enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seven_seg_scanner: NUM_DIGITS must be 1..8");
    end
    if (SCAN_DIV < 8) begin : g_bad_div
        $error("seven_seg_scanner: SCAN_DIV must be at least 8");
    end

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] EN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_PIN = {7{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_PIN_OFF = SEG_OFF ^ SEG_PIN;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
        logic                    blank_lz;
        logic [2:0]              bright;
    } shadow_t;

    logic [PW-1:0]                 pre;
    logic [IW-1:0]                 idx;
    logic                          snap;
    shadow_t                       sh, cur;
    logic [NUM_DIGITS-1:0][3:0]    nib;
    logic [NUM_DIGITS-1:0]         blank;
    logic [NUM_DIGITS-1:0]         onehot;
    logic                          dp_sel;
    logic [31:0]                   thr;
    logic                          lit;
    logic [6:0]                    code;

    assign snap = (pre == '0) && (idx == '0);

    // The snapshot cycle already displays the freshly captured inputs, so a frame is coherent end to end.
    always_comb begin
        cur = sh;
        if (snap) begin
            cur.value    = value;
            cur.dp       = dp_in;
            cur.blank_lz = blank_lz;
            cur.bright   = bright;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
        assign nib[i] = cur.value[4*(NUM_DIGITS-1-i) +: 4];
    end

    // Running OR from the leftmost digit: a digit is blank while everything up to it is zero.
    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            acc      = acc | (|nib[i]);
            blank[i] = cur.blank_lz && (i < NUM_DIGITS - 1) && !acc;
        end
    end

    always_comb begin
        onehot = '0;
        dp_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                onehot[NUM_DIGITS-1-i] = 1'b1;
                dp_sel                 = cur.dp[NUM_DIGITS-1-i];
            end
        end
    end

    assign thr = ((32'(cur.bright) + 32'd1) * 32'(SCAN_DIV)) >> 3;
    assign lit = (32'(pre) < thr) && !blank[idx];

    seg7_decode u_dec (
        .nib  (nib[idx]),
        .code (code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre        <= '0;
            idx        <= '0;
            sh         <= '0;
            frame_tick <= 1'b0;
            enable     <= EN_OFF;
            seg        <= SEG_PIN_OFF;
            dp         <= ACTIVE_LOW;
        end else begin
            if (pre == PW'(SCAN_DIV - 1)) begin
                pre <= '0;
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                pre <= pre + PW'(1);
            end
            if (snap) sh <= cur;
            frame_tick <= snap;
            if (lit) begin
                enable <= onehot ^ EN_OFF;
                seg    <= code ^ SEG_PIN;
                dp     <= dp_sel ^ ACTIVE_LOW;
            end else begin
                enable <= EN_OFF;
                seg    <= SEG_PIN_OFF;
                dp     <= ACTIVE_LOW;
            end
        end
    end

endmodule
